vliw_pipe_stage: RTL and testbench
==================================

Name: vliw_pipe_stage

Overview:
- Generic, parametrised inter-stage pipeline register for the VLIW datapath. It replaces the hand-instantiated per-signal latch banks between IF/ID/EX/MEM/WB.
- Carries SLOTS parallel issue slots. Each slot has a WIDTH-bit payload and CTRL_W control bits.
- Adds a valid/ready handshake with a 2-entry skid buffer, so backpressure does not combinationally reach the upstream stage.
- Adds a whole-stage flush, per-slot kill (bubble insertion) and a saturating stall-cycle counter.

Parameters:
- WIDTH, 32, payload bits per slot (pc, operands, immediates packed by the parent).
- CTRL_W, 16, control bits per slot (regWrite, memRead/memWrite, flag writes, aluOp, …). All-zero means no side effect.
- SLOTS, 2, number of issue slots; legal range 1..4.
- CNT_W, 8, stall counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream bundle valid.
- in_ready  out  1  stage can accept a bundle this cycle.
- in_data  in  SLOTS*WIDTH  payload; slot k occupies bits [k*WIDTH +: WIDTH].
- in_ctrl  in  SLOTS*CTRL_W  control; slot k occupies bits [k*CTRL_W +: CTRL_W].
- in_kill  in  SLOTS  per-slot kill, sampled together with the bundle.
- flush  in  1  discard all held bundles and the incoming bundle.
- out_valid  out  1  output bundle valid.
- out_ready  in  1  downstream accepts the bundle.
- out_data  out  SLOTS*WIDTH  held payload.
- out_ctrl  out  SLOTS*CTRL_W  held control, zeroed for killed or invalid slots.
- out_slot_valid  out  SLOTS  per-slot live flag.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Reset state: the following are all 0: main register valid (main_v), skid valid (skid_v), out_data, out_ctrl, out_slot_valid and stall_cnt. in_ready=1.
- Reset dominates flush and all transfers in the same cycle.
- Handshake:
  - Input accept = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - in_ready is registered and equals ~skid_v of the current cycle. It never depends combinationally on out_ready.
  - out_valid = main_v.
- Entry capture, applied to every accepted bundle:
  - Per slot k: slot_valid[k] = ~in_kill[k].
  - ctrl[k] = in_kill[k] ? 0 : in_ctrl[k].
  - data[k] is always captured, even when the slot is killed.
- Data movement, per cycle with no flush:
  - Main empty, or main transferring out, with skid empty: an accepted bundle loads main.
  - Main full, not transferring, skid empty: an accepted bundle loads skid; in_ready falls next cycle.
  - Main transferring out with skid full: skid moves to main, skid empties, in_ready rises next cycle. No accept is possible this cycle because in_ready=0.
  - No transfer and no accept: hold. out_* stays stable while out_valid=1 and out_ready=0.
- Latency and ordering:
  - 1 cycle from accept to out_valid when main is empty.
  - Sustained throughput is 1 bundle/cycle with out_ready held high.
  - Bundle order is strictly preserved.
- Flush:
  - Next state: main_v=0, skid_v=0, in_ready=1, out_ctrl=0, out_slot_valid=0.
  - The bundle offered in the flush cycle is dropped.
  - An output transfer in the flush cycle still completes, since downstream sampled it.
  - out_data keeps its old value (don't-care).
- Bundle with all slots killed: still a valid bundle (out_valid=1, out_slot_valid=0, ctrl=0). It occupies one slot-time, matching a hardware nop.
- Stall counter:
  - Increments when out_valid & ~out_ready.
  - Holds at 2^CNT_W-1.
  - Clears on reset, on flush, and on the cycle after any output transfer.
- Width rules: slot packing is little-endian by slot index. There is no arithmetic on payload.

Test Plan:
- Reset then idle: after reset, in_ready=1, out_valid=0, out_ctrl=0, stall_cnt=0.
- Streaming:
  - Stimulus: SLOTS=2, out_ready=1, bundles data {0x11111111,0x22222222} then {0x33333333,0x44444444} on consecutive cycles.
  - Response: each appears on out_data exactly 1 cycle later; out_valid high for 2 cycles; in_ready stays 1.
- Backpressure/skid:
  - Stimulus: out_ready=0, three back-to-back bundles A,B,C.
  - Response: A held on the output; B lands in skid; in_ready=0 on the cycle C is offered, so C is not accepted.
  - Then raise out_ready: A, B, then C (re-offered) emerge in order.
  - stall_cnt counts 1,2,… during the hold, then clears.
- Per-slot kill:
  - Stimulus: in_kill=2'b10, in_ctrl slot1=0xFFFF.
  - Response: out_slot_valid=2'b01, out_ctrl slot1=0x0000, slot0 ctrl unchanged, out_valid=1.
- Flush mid-stall:
  - Stimulus: main and skid full, out_ready=0, flush=1 together with in_valid=1.
  - Response: next cycle out_valid=0, in_ready=1, stall_cnt=0, out_ctrl=0; the offered bundle is never output.
- Reset mid-operation and saturation:
  - Stimulus: CNT_W=4, stall for 20 cycles.
  - Response: stall_cnt reaches 15 and holds.
  - Then assert reset together with in_valid and flush: next cycle shows the full reset state and the offered bundle is dropped.

Source files
------------

// File: rtl/vliw_pipe_stage.sv
// vliw_pipe_stage: multi-slot VLIW pipeline register with skid buffer, flush, per-slot kill and stall counter
module vliw_pipe_stage #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 16,
  parameter int SLOTS  = 2,
  parameter int CNT_W  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SLOTS*WIDTH-1:0]    in_data,
  input  logic [SLOTS*CTRL_W-1:0]   in_ctrl,
  input  logic [SLOTS-1:0]          in_kill,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SLOTS*WIDTH-1:0]    out_data,
  output logic [SLOTS*CTRL_W-1:0]   out_ctrl,
  output logic [SLOTS-1:0]          out_slot_valid,
  output logic [CNT_W-1:0]          stall_cnt
);
  localparam int DW = SLOTS * WIDTH;
  localparam int CW = SLOTS * CTRL_W;
  logic             main_v_q, main_v_d, skid_v_q, skid_v_d, in_ready_q, in_ready_d;
  logic [DW-1:0]    main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [CW-1:0]    main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d, cap_ctrl;
  logic [SLOTS-1:0] main_sv_q, main_sv_d, skid_sv_q, skid_sv_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             acc, xfer;
  assign acc  = in_valid & in_ready_q;
  assign xfer = main_v_q & out_ready;
  for (genvar k = 0; k < SLOTS; k++) begin : g_cap
    assign cap_ctrl[k*CTRL_W +: CTRL_W] = in_kill[k] ? '0 : in_ctrl[k*CTRL_W +: CTRL_W];
  end
  // Main ctrl/slot-valid are cleared whenever main empties, so outputs need no gating.
  always_comb begin
    main_v_d    = main_v_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    main_sv_d   = main_sv_q;
    skid_v_d    = skid_v_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_sv_d   = skid_sv_q;
    if (flush) begin
      main_v_d    = 1'b0;
      skid_v_d    = 1'b0;
      main_ctrl_d = '0;
      main_sv_d   = '0;
    end else if (skid_v_q) begin
      if (xfer) begin
        main_data_d = skid_data_q;
        main_ctrl_d = skid_ctrl_q;
        main_sv_d   = skid_sv_q;
        skid_v_d    = 1'b0;
      end
    end else if (!main_v_q || xfer) begin
      main_v_d    = acc;
      main_data_d = acc ? in_data : main_data_q;
      main_ctrl_d = acc ? cap_ctrl : '0;
      main_sv_d   = acc ? ~in_kill : '0;
    end else if (acc) begin
      skid_v_d    = 1'b1;
      skid_data_d = in_data;
      skid_ctrl_d = cap_ctrl;
      skid_sv_d   = ~in_kill;
    end
    in_ready_d  = ~skid_v_d;
    stall_cnt_d = (flush || xfer) ? '0 :
                  (main_v_q && !out_ready && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      main_v_q    <= 1'b0;
      skid_v_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      main_sv_q   <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_sv_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      main_v_q    <= main_v_d;
      skid_v_q    <= skid_v_d;
      in_ready_q  <= in_ready_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      main_sv_q   <= main_sv_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_sv_q   <= skid_sv_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign in_ready       = in_ready_q;
  assign out_valid      = main_v_q;
  assign out_data       = main_data_q;
  assign out_ctrl       = main_ctrl_q;
  assign out_slot_valid = main_sv_q;
  assign stall_cnt      = stall_cnt_q;
endmodule

// File: tb/tb_vliw_pipe_stage.sv
// tb_vliw_pipe_stage: directed and randomized checks of vliw_pipe_stage against a queue-based bundle model
module tb_vliw_pipe_stage;
  localparam int WIDTH = 32, CTRL_W = 16, SLOTS = 2, CNT_W = 4;
  localparam int DW = SLOTS * WIDTH, CW = SLOTS * CTRL_W;
  localparam int CMAX = (1 << CNT_W) - 1;
  typedef struct {
    logic [DW-1:0]    d;
    logic [CW-1:0]    c;
    logic [SLOTS-1:0] v;
  } bundle_t;
  logic clk, reset, in_valid, in_ready, flush, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [SLOTS-1:0] in_kill, out_slot_valid;
  logic [CNT_W-1:0] stall_cnt;
  bundle_t q[$];
  int m_cnt;
  int n_chk = 0, n_fail = 0;
  vliw_pipe_stage #(.WIDTH(WIDTH), .CTRL_W(CTRL_W), .SLOTS(SLOTS), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_ctrl(in_ctrl), .in_kill(in_kill), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .out_slot_valid(out_slot_valid), .stall_cnt(stall_cnt)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // Model: the stage is a FIFO of at most two bundles; accept only when fewer than two are held.
  task automatic step();
    bundle_t b;
    bit acc, xfer;
    acc  = in_valid && (q.size() < 2);
    xfer = (q.size() > 0) && out_ready;
    b.d = in_data;
    b.v = ~in_kill;
    for (int k = 0; k < SLOTS; k++) b.c[k*CTRL_W +: CTRL_W] = in_kill[k] ? '0 : in_ctrl[k*CTRL_W +: CTRL_W];
    if (reset || flush) begin
      q.delete();
      m_cnt = 0;
    end else begin
      if (xfer) m_cnt = 0;
      else if (q.size() > 0 && !out_ready && m_cnt < CMAX) m_cnt = m_cnt + 1;
      if (xfer) void'(q.pop_front());
      if (acc) q.push_back(b);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    in_valid = 0; flush = 0; in_kill = '0; in_ctrl = '0; in_data = '0; out_ready = 1;
  endtask
  task automatic test_reset();
    reset = 1; idle();
    step(); step();
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    n_chk++; if (out_ctrl !== '0) begin n_fail++; $display("FAIL reset_out_ctrl: got %h want 0", out_ctrl); end
    n_chk++; if (stall_cnt !== '0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
    n_chk++; if (out_data !== '0 || out_slot_valid !== '0) begin n_fail++; $display("FAIL reset_data_sv: got %h/%b want 0/0", out_data, out_slot_valid); end
    reset = 0;
    step();
    n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL idle: got v=%0b r=%0b want 0/1", out_valid, in_ready); end
  endtask
  task automatic test_streaming();
    idle();
    in_valid = 1; in_data = {32'h22222222, 32'h11111111}; in_ctrl = 32'h00020001;
    step();
    n_chk++; if (out_valid !== 1'b1 || out_data !== 64'h22222222_11111111) begin n_fail++; $display("FAIL stream_a: got v=%0b d=%h want 1/%h", out_valid, out_data, 64'h22222222_11111111); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready_a: got %0b want 1", in_ready); end
    in_data = {32'h44444444, 32'h33333333};
    step();
    n_chk++; if (out_valid !== 1'b1 || out_data !== 64'h44444444_33333333) begin n_fail++; $display("FAIL stream_b: got v=%0b d=%h want 1/%h", out_valid, out_data, 64'h44444444_33333333); end
    n_chk++; if (in_ready !== 1'b1 || out_ctrl !== 32'h00020001) begin n_fail++; $display("FAIL stream_ready_ctrl_b: got r=%0b c=%h want 1/00020001", in_ready, out_ctrl); end
    in_valid = 0;
    step();
    n_chk++; if (out_valid !== 1'b0 || out_ctrl !== '0) begin n_fail++; $display("FAIL stream_drain: got v=%0b c=%h want 0/0", out_valid, out_ctrl); end
  endtask
  task automatic test_backpressure();
    idle(); out_ready = 0; in_valid = 1;
    in_data = 64'hA; step();
    n_chk++; if (out_data !== 64'hA || in_ready !== 1'b1 || stall_cnt !== 4'd0) begin n_fail++; $display("FAIL bp_a: got d=%h r=%0b s=%0d want a/1/0", out_data, in_ready, stall_cnt); end
    in_data = 64'hB; step();
    n_chk++; if (out_data !== 64'hA || in_ready !== 1'b0 || stall_cnt !== 4'd1) begin n_fail++; $display("FAIL bp_b: got d=%h r=%0b s=%0d want a/0/1", out_data, in_ready, stall_cnt); end
    in_data = 64'hC; step(); step();
    n_chk++; if (out_data !== 64'hA || in_ready !== 1'b0 || stall_cnt !== 4'd3) begin n_fail++; $display("FAIL bp_c_blocked: got d=%h r=%0b s=%0d want a/0/3", out_data, in_ready, stall_cnt); end
    out_ready = 1; step();
    n_chk++; if (out_data !== 64'hB || in_ready !== 1'b1 || stall_cnt !== 4'd0) begin n_fail++; $display("FAIL bp_b_out: got d=%h r=%0b s=%0d want b/1/0", out_data, in_ready, stall_cnt); end
    step();
    n_chk++; if (out_data !== 64'hC || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_c_out: got d=%h v=%0b want c/1", out_data, out_valid); end
    in_valid = 0; step();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %0b want 0", out_valid); end
  endtask
  task automatic test_kill();
    idle(); in_valid = 1; in_kill = 2'b10; in_ctrl = {16'hFFFF, 16'h1234}; in_data = 64'hBBBB0002_AAAA0001;
    step();
    n_chk++; if (out_slot_valid !== 2'b01 || out_ctrl !== 32'h00001234) begin n_fail++; $display("FAIL kill_slot1: got sv=%b c=%h want 01/00001234", out_slot_valid, out_ctrl); end
    n_chk++; if (out_valid !== 1'b1 || out_data !== 64'hBBBB0002_AAAA0001) begin n_fail++; $display("FAIL kill_data: got v=%0b d=%h want 1/bbbb0002aaaa0001", out_valid, out_data); end
    in_kill = 2'b11; step();
    n_chk++; if (out_valid !== 1'b1 || out_slot_valid !== 2'b00 || out_ctrl !== '0) begin n_fail++; $display("FAIL kill_all: got v=%0b sv=%b c=%h want 1/00/0", out_valid, out_slot_valid, out_ctrl); end
    idle(); step();
  endtask
  task automatic test_flush();
    idle(); out_ready = 0; in_valid = 1; in_ctrl = 32'h5555AAAA;
    in_data = 64'h1; step();
    in_data = 64'h2; step();
    in_data = 64'hDEAD; flush = 1; step();
    n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_vr: got v=%0b r=%0b want 0/1", out_valid, in_ready); end
    n_chk++; if (stall_cnt !== '0 || out_ctrl !== '0 || out_slot_valid !== '0) begin n_fail++; $display("FAIL flush_state: got s=%0d c=%h sv=%b want 0/0/0", stall_cnt, out_ctrl, out_slot_valid); end
    flush = 0; in_valid = 0; out_ready = 1; step();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_dropped: got %0b want 0", out_valid); end
  endtask
  task automatic test_saturation();
    idle(); out_ready = 0; in_valid = 1; in_data = 64'h77; in_ctrl = 32'h1; step();
    in_valid = 0;
    for (int i = 0; i < 20; i++) step();
    n_chk++; if (stall_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_cnt: got %0d want 15", stall_cnt); end
    n_chk++; if (out_valid !== 1'b1 || out_data !== 64'h77) begin n_fail++; $display("FAIL sat_hold: got v=%0b d=%h want 1/77", out_valid, out_data); end
    reset = 1; flush = 1; in_valid = 1; in_data = 64'h99; step();
    n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || stall_cnt !== '0) begin n_fail++; $display("FAIL rst_mid_vrs: got v=%0b r=%0b s=%0d want 0/1/0", out_valid, in_ready, stall_cnt); end
    n_chk++; if (out_data !== '0 || out_ctrl !== '0 || out_slot_valid !== '0) begin n_fail++; $display("FAIL rst_mid_out: got d=%h c=%h sv=%b want 0/0/0", out_data, out_ctrl, out_slot_valid); end
    reset = 0; idle(); step();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_dropped: got %0b want 0", out_valid); end
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 15) == 0);
      in_kill   = SLOTS'($urandom);
      in_ctrl   = CW'($urandom);
      in_data   = {$urandom, $urandom};
      step();
      n_chk++; if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin n_fail++; $display("FAIL rand_vr[%0d]: got v=%0b r=%0b want %0b/%0b", i, out_valid, in_ready, q.size() > 0, q.size() < 2); end
      n_chk++; if (stall_cnt !== CNT_W'(m_cnt)) begin n_fail++; $display("FAIL rand_stall[%0d]: got %0d want %0d", i, stall_cnt, m_cnt); end
      if (q.size() > 0) begin
        n_chk++; if (out_data !== q[0].d || out_ctrl !== q[0].c || out_slot_valid !== q[0].v) begin n_fail++; $display("FAIL rand_bundle[%0d]: got %h/%h/%b want %h/%h/%b", i, out_data, out_ctrl, out_slot_valid, q[0].d, q[0].c, q[0].v); end
      end else begin
        n_chk++; if (out_ctrl !== '0 || out_slot_valid !== '0) begin n_fail++; $display("FAIL rand_empty[%0d]: got c=%h sv=%b want 0/0", i, out_ctrl, out_slot_valid); end
      end
    end
    idle(); step(); step(); step();
  endtask
  initial begin
    m_cnt = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_kill();
    test_flush();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
